// File: rtl/hex_score_pkg.sv
// Shared types and constants for the seven-segment score writer.
package hex_score_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    CMP   = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Largest score the four digits can show.
  localparam int MAX_SCORE = 9999;

  // Four packed BCD digits.
  localparam int BCD_W = 16;

  // Word address of the PIO data register, unless the top overrides it.
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Double-dabble correction step: every digit of 5 or more gets 3 added,
  // so that the shift that follows carries it into the next digit.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] value);
    logic [BCD_W-1:0] result;
    result = value;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (value[4*i +: 4] >= 4'd5) begin
        result[4*i +: 4] = value[4*i +: 4] + 4'd3;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift/add-3 step per cycle,
// BIN_W cycles per conversion. done is high during the final step.
module bin2bcd_seq
  import hex_score_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [CNT_W-1:0] count;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_adj;

  // Digit correction applied to the current BCD value before it shifts.
  always_comb begin
    bcd_adj = bcd_add3(bcd_q);
  end

  // Load on start, then shift {bcd, bin} left once per cycle until the count runs out.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else if (start) begin
      count <= CNT_W'(BIN_W);
      bin_q <= bin;
      bcd_q <= '0;
    end else if (count != '0) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
      count          <= count - 1'b1;
    end
  end

  assign busy = (count != '0);
  assign done = (count == CNT_W'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/hex_score_writer.sv
// Score-to-PIO writer: accepts a binary score, clamps it to 9999, converts
// it to BCD and writes the digits to the PIO data register over Avalon-MM,
// skipping the write when the displayed digits would not change.
module hex_score_writer
  import hex_score_pkg::*;
#(
  parameter int         BIN_W    = 14,
  parameter logic [1:0] PIO_ADDR = PIO_DATA_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             score_valid,
  output logic             score_ready,
  input  logic [BIN_W-1:0] score_bin,
  output logic             saturated,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic             avm_waitrequest
);

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_SCORE);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             over_max;
  logic [BIN_W-1:0] score_clamped;
  logic             conv_start;
  logic             conv_busy;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             load_wdata;
  logic             commit;
  logic [BCD_W-1:0] last_written;

  assign avm_address = PIO_ADDR;

  // Handshake and clamp: only accept in IDLE with the converter free and reset low.
  always_comb begin
    score_ready   = (state == IDLE) && !conv_busy && !reset;
    accept        = score_valid && score_ready;
    over_max      = (score_bin > MAX_BIN);
    score_clamped = over_max ? MAX_BIN : score_bin;
  end

  bin2bcd_seq #(
    .BIN_W (BIN_W)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (score_clamped),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and bus strobes; the write strobes are a pure decode of WRITE.
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    conv_start     = 1'b0;
    load_wdata     = 1'b0;
    commit         = 1'b0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    unique case (state)
      IDLE: begin
        if (accept) begin
          conv_start = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          state_next = CMP;
        end
      end
      CMP: begin
        if (conv_bcd == last_written) begin
          state_next = IDLE;
        end else begin
          load_wdata = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        if (!avm_waitrequest) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Saturation pulse, write data holding register and the dedupe shadow of the PIO.
  always_ff @(posedge clk) begin
    if (reset) begin
      saturated     <= 1'b0;
      avm_writedata <= '0;
      last_written  <= '0;
    end else begin
      saturated <= accept && over_max;
      if (load_wdata) begin
        avm_writedata <= {{(32 - BCD_W){1'b0}}, conv_bcd};
      end
      if (commit) begin
        last_written <= avm_writedata[BCD_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hex_score_writer.sv
// Self-checking bench for hex_score_writer: directed and random scores,
// expectations from a decimal-arithmetic model, checked by a bus monitor.
module tb_hex_score_writer;

  localparam int BIN_W   = 14;
  localparam int BIN_W16 = 16;
  localparam int MAX_TB  = 9999;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             score_valid;
  logic             score_ready;
  logic [BIN_W-1:0] score_bin;
  logic             saturated;
  logic [1:0]       avm_address;
  logic             avm_chipselect;
  logic             avm_write_n;
  logic [31:0]      avm_writedata;
  logic             avm_waitrequest;

  logic               valid16;
  logic               ready16;
  logic [BIN_W16-1:0] bin16;
  logic               sat16;
  logic [1:0]         addr16;
  logic               cs16;
  logic               wn16;
  logic [31:0]        wdata16;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic        sat_q[$];
  logic [15:0] model_last;
  int          stall_req  = 0;
  int          stall_done = 0;
  logic        acc_flag   = 1'b0;

  hex_score_writer #(.BIN_W(BIN_W), .PIO_ADDR(2'd0)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .score_valid     (score_valid),
    .score_ready     (score_ready),
    .score_bin       (score_bin),
    .saturated       (saturated),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_write_n     (avm_write_n),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest)
  );

  hex_score_writer #(.BIN_W(BIN_W16), .PIO_ADDR(2'd0)) u_dut16 (
    .clk             (clk),
    .reset           (reset),
    .score_valid     (valid16),
    .score_ready     (ready16),
    .score_bin       (bin16),
    .saturated       (sat16),
    .avm_address     (addr16),
    .avm_chipselect  (cs16),
    .avm_write_n     (wn16),
    .avm_writedata   (wdata16),
    .avm_waitrequest (1'b0)
  );

  // Slave model: stall each write for stall_req cycles.
  assign avm_waitrequest = avm_chipselect && (stall_done < stall_req);

  always @(posedge clk) begin
    if (reset || (score_valid && score_ready)) stall_done <= 0;
    else if (avm_chipselect && avm_waitrequest) stall_done <= stall_done + 1;
    acc_flag <= score_valid && score_ready;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: decimal digits of min(score, 9999).
  function automatic logic [15:0] to_bcd(input int s);
    int c;
    c = (s > MAX_TB) ? MAX_TB : s;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  // Monitor: saturation after each accept, and every write cycle against the scoreboard.
  always @(negedge clk) begin
    if (acc_flag) begin
      if (sat_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sat_scoreboard_empty got=accept expected=none at %0t", $time);
      end else begin
        check("saturated", 32'(saturated), 32'(sat_q.pop_front()));
      end
    end else if (saturated) begin
      check("saturated_spurious", 32'(saturated), 32'd0);
    end
    if (avm_chipselect) begin
      check("write_n", 32'(avm_write_n), 32'd0);
      check("address", 32'(avm_address), 32'd0);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write got=%0h expected=no_write at %0t", avm_writedata, $time);
      end else begin
        check("writedata", avm_writedata, {16'h0000, exp_q[0]});
        if (!avm_waitrequest) void'(exp_q.pop_front());
      end
    end else begin
      check("write_n_idle", 32'(avm_write_n), 32'd1);
    end
  end

  task automatic issue(input int score, output int lat_exp);
    logic [15:0] b;
    b = to_bcd(score);
    sat_q.push_back(score > MAX_TB);
    if (b != model_last) begin
      exp_q.push_back(b);
      model_last = b;
      lat_exp = BIN_W + 3 + stall_req;
    end else begin
      lat_exp = BIN_W + 2;
    end
    score_bin   = BIN_W'(score);
    score_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    while (!score_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!score_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout got=not_ready expected=ready at %0t", $time);
    end
    @(posedge clk);
    #1 score_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat_exp);
    int lat;
    lat = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (score_ready) begin
        lat = c;
        break;
      end
    end
    check(name, 32'(lat), 32'(lat_exp));
  endtask

  task automatic do_txn(input int score, input int stall, input string name);
    int le;
    @(negedge clk);
    stall_req = stall;
    issue(score, le);
    wait_accept();
    wait_done(name, le);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int le;
    int prev;
    int lat;
    reset       = 1'b1;
    score_valid = 1'b0;
    score_bin   = '0;
    valid16     = 1'b0;
    bin16       = '0;
    model_last  = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_chipselect", 32'(avm_chipselect), 32'd0);
    check("rst_write_n", 32'(avm_write_n), 32'd1);
    check("rst_writedata", avm_writedata, 32'd0);
    check("rst_saturated", 32'(saturated), 32'd0);
    check("rst_ready", 32'(score_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1 check("ready_after_reset", 32'(score_ready), 32'd1);

    do_txn(1234, 0, "lat_1234");
    do_txn(1234, 0, "lat_1234_dedupe");
    do_txn(12000, 0, "lat_12000_sat");
    do_txn(5678, 3, "lat_5678_stall3");

    // Second score held on the port while the first is still in flight.
    @(negedge clk);
    stall_req = 0;
    issue(100, le);
    wait_accept();
    issue(42, le);
    wait_accept();
    wait_done("lat_42_held", le);

    // Reset during conversion aborts without a write.
    @(negedge clk);
    issue(4321, le);
    wait_accept();
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_chipselect", 32'(avm_chipselect), 32'd0);
    check("abort_write_n", 32'(avm_write_n), 32'd1);
    check("abort_writedata", avm_writedata, 32'd0);
    check("abort_saturated", 32'(saturated), 32'd0);
    check("abort_ready", 32'(score_ready), 32'd0);
    exp_q.delete();
    sat_q.delete();
    model_last = 16'h0000;
    reset = 1'b0;
    do_txn(0, 0, "lat_zero_dedupe_reset");

    prev = 0;
    for (int i = 0; i < 24; i++) begin
      int s;
      s = ($urandom_range(0, 3) == 0) ? prev : int'($urandom_range(0, 16383));
      do_txn(s, int'($urandom_range(0, 3)), "lat_random");
      prev = s;
    end

    // 16-bit build: full-scale input saturates to 9999.
    @(negedge clk);
    bin16   = 16'hFFFF;
    valid16 = 1'b1;
    check("ready16", 32'(ready16), 32'd1);
    @(posedge clk);
    #1 valid16 = 1'b0;
    @(negedge clk);
    check("sat16", 32'(sat16), 32'd1);
    lat = 0;
    for (int c = 2; c <= 100; c++) begin
      @(negedge clk);
      if (cs16) begin
        lat = c;
        break;
      end
    end
    check("write16_cycle", 32'(lat), 32'(BIN_W16 + 2));
    check("wdata16", wdata16, 32'h0000_9999);
    check("wn16", 32'(wn16), 32'd0);
    check("addr16", 32'(addr16), 32'd0);

    repeat (4) @(negedge clk);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    check("sat_outstanding", 32'(sat_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
